// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the NPC control sequencer: state encoding, halt cause
// codes, the default reset PC and a small PC alignment helper.
// -----------------------------------------------------------------------------
package npc_pkg;

    // State encodings; all eight codes of the 3-bit field are used.
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC = 3'd1;
    localparam logic [2:0] ST_IWAIT_ENC = 3'd2;
    localparam logic [2:0] ST_EXEC_ENC  = 3'd3;
    localparam logic [2:0] ST_MEM_ENC   = 3'd4;
    localparam logic [2:0] ST_MWAIT_ENC = 3'd5;
    localparam logic [2:0] ST_WB_ENC    = 3'd6;
    localparam logic [2:0] ST_HALT_ENC  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_FETCH = ST_FETCH_ENC,
        ST_IWAIT = ST_IWAIT_ENC,
        ST_EXEC  = ST_EXEC_ENC,
        ST_MEM   = ST_MEM_ENC,
        ST_MWAIT = ST_MWAIT_ENC,
        ST_WB    = ST_WB_ENC,
        ST_HALT  = ST_HALT_ENC
    } npc_state_t;

    // Halt cause codes reported on halt_code.
    localparam logic [2:0] HALT_NONE     = 3'd0;
    localparam logic [2:0] HALT_EBREAK   = 3'd1;
    localparam logic [2:0] HALT_ILLEGAL  = 3'd2;
    localparam logic [2:0] HALT_MISALIGN = 3'd3;
    localparam logic [2:0] HALT_TIMEOUT  = 3'd4;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

    // A PC is usable only when word aligned.
    function automatic logic pc_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/npc_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// npc_ctrl_watchdog
// Bus wait timer for the NPC sequencer. Counts consecutive cycles spent in a
// wait state and flags expiry when the configured limit is reached with no
// response in sight.
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   i_waiting     sequencer is in IWAIT or MWAIT this cycle
//   i_rsp_valid   the awaited response is present this cycle
//   o_expired     wait budget used up without a response (next state = HALT)
// -----------------------------------------------------------------------------
module npc_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_waiting,
    input  logic i_rsp_valid,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // r_count holds the number of wait cycles already completed, so the
    // last allowed wait cycle is the one where it equals LIMIT.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter: cleared outside wait states, saturates at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_waiting) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= r_count;
        end
    end

    // A response on the final cycle still wins over the timeout.
    assign o_expired = i_waiting & ~i_rsp_valid & (r_count == LIMIT);

endmodule

// File: rtl/npc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// npc_ctrl_fsm
// Multi-cycle control sequencer for the NPC core. Owns PC and instruction
// register, drives the fetch and data-memory handshakes and steps the datapath
// through FETCH/IWAIT/EXEC/MEM/MWAIT/WB, halting on illegal, ebreak, misaligned
// next PC or (optionally) bus timeout.
//
// Optional feature macro: NPC_CTRL_TIMEOUT_EN enables the wait watchdog
// (halt code 4 after TIMEOUT_CYCLES waiting cycles in IWAIT/MWAIT).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr fetch request handshake (addr = pc)
//   imem_rsp_valid, imem_rdata      fetched instruction
//   inst, inst_valid                instruction register to decoders, valid in EXEC
//   dec_*                           decode flags, sampled in EXEC
//   next_pc                         datapath next PC, sampled in WB
//   dmem_req_valid/we/ready         data request handshake
//   dmem_rsp_valid                  load data / store acknowledge
//   pc, rf_we, retire, minstret     architectural status
//   halted, halt_code               sticky halt and its cause
// -----------------------------------------------------------------------------
module npc_ctrl_fsm
    import npc_pkg::*;
#(
    parameter logic [31:0] PC_RESET       = PC_RESET_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_rd_wen,
    input  logic        dec_ebreak,
    input  logic        dec_illegal,
    input  logic [31:0] next_pc,
    output logic        dmem_req_valid,
    output logic        dmem_we,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic        retire,
    output logic [63:0] minstret,
    output logic        halted,
    output logic [2:0]  halt_code
);

    npc_state_t  r_state;
    npc_state_t  w_state_nxt;
    logic [2:0]  r_halt_code;
    logic [2:0]  w_halt_code_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_minstret;
    logic        r_st;
    logic        r_wen;
    logic        w_retire;
    logic        w_timeout;

`ifdef NPC_CTRL_TIMEOUT_EN
    logic w_waiting;
    logic w_wait_rsp;

    assign w_waiting  = (r_state == ST_IWAIT) | (r_state == ST_MWAIT);
    assign w_wait_rsp = (r_state == ST_IWAIT) ? imem_rsp_valid : dmem_rsp_valid;

    npc_ctrl_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_waiting   (w_waiting),
        .i_rsp_valid (w_wait_rsp),
        .o_expired   (w_timeout)
    );
`else
    // Without the watchdog, waits are unbounded.
    assign w_timeout = 1'b0;
`endif

    // Commit happens in WB only when the next PC is usable.
    assign w_retire = (r_state == ST_WB) & ~pc_misaligned(next_pc);

    // Next-state and halt-cause selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_halt_code_nxt = r_halt_code;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // Late fetch responses are ignored here; only acceptance matters.
                if (imem_req_ready) begin
                    w_state_nxt = ST_IWAIT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_IWAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_HALT;
                    w_halt_code_nxt = HALT_TIMEOUT;
                end else begin
                    w_state_nxt = ST_IWAIT;
                end
            end
            ST_EXEC: begin
                // Illegal outranks ebreak when a decoder raises both.
                if (dec_illegal) begin
                    w_state_nxt     = ST_HALT;
                    w_halt_code_nxt = HALT_ILLEGAL;
                end else if (dec_ebreak) begin
                    w_state_nxt     = ST_HALT;
                    w_halt_code_nxt = HALT_EBREAK;
                end else if (dec_load | dec_store) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_req_ready) begin
                    w_state_nxt = ST_MWAIT;
                end else begin
                    w_state_nxt = ST_MEM;
                end
            end
            ST_MWAIT: begin
                if (dmem_rsp_valid) begin
                    w_state_nxt = ST_WB;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_HALT;
                    w_halt_code_nxt = HALT_TIMEOUT;
                end else begin
                    w_state_nxt = ST_MWAIT;
                end
            end
            ST_WB: begin
                if (pc_misaligned(next_pc)) begin
                    w_state_nxt     = ST_HALT;
                    w_halt_code_nxt = HALT_MISALIGN;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt     = ST_HALT;
                w_halt_code_nxt = r_halt_code;
            end
        endcase
    end

    // State and sticky halt cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_halt_code <= HALT_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_code <= w_halt_code_nxt;
        end
    end

    // Instruction register, loaded from the fetch response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst <= 32'h0000_0000;
        end else if ((r_state == ST_IWAIT) && imem_rsp_valid) begin
            r_inst <= imem_rdata;
        end else begin
            r_inst <= r_inst;
        end
    end

    // Decode flags needed after EXEC (store direction, register write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= 1'b0;
            r_wen <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_st  <= dec_store;
            r_wen <= dec_rd_wen;
        end else begin
            r_st  <= r_st;
            r_wen <= r_wen;
        end
    end

    // PC and retired-instruction counter advance on commit; counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= PC_RESET;
            r_minstret <= 64'd0;
        end else if (w_retire) begin
            r_pc       <= next_pc;
            r_minstret <= r_minstret + 64'd1;
        end else begin
            r_pc       <= r_pc;
            r_minstret <= r_minstret;
        end
    end

    // Handshake outputs come from state and registers only.
    assign imem_req_valid = (r_state == ST_FETCH);
    assign imem_addr      = r_pc;
    assign inst           = r_inst;
    assign inst_valid     = (r_state == ST_EXEC);
    assign dmem_req_valid = (r_state == ST_MEM);
    assign dmem_we        = (r_state == ST_MEM) & r_st;
    assign pc             = r_pc;
    assign rf_we          = (r_state == ST_WB) & r_wen & ~r_st;
    assign retire         = w_retire;
    assign minstret       = r_minstret;
    assign halted         = (r_state == ST_HALT);
    assign halt_code      = r_halt_code;

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_npc_ctrl_fsm
// Directed bench for npc_ctrl_fsm. Inputs change and outputs are sampled on
// the falling clock edge; the DUT state advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_npc_ctrl_fsm;

    localparam logic [31:0] PC0 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rdata, inst, next_pc, pc;
    logic        inst_valid;
    logic        dec_load, dec_store, dec_rd_wen, dec_ebreak, dec_illegal;
    logic        dmem_req_valid, dmem_we, dmem_req_ready, dmem_rsp_valid;
    logic        rf_we, retire, halted;
    logic [63:0] minstret;
    logic [2:0]  halt_code;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk = ~clk;

    npc_ctrl_fsm #(
        .PC_RESET       (PC0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .dec_load       (dec_load),
        .dec_store      (dec_store),
        .dec_rd_wen     (dec_rd_wen),
        .dec_ebreak     (dec_ebreak),
        .dec_illegal    (dec_illegal),
        .next_pc        (next_pc),
        .dmem_req_valid (dmem_req_valid),
        .dmem_we        (dmem_we),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .pc             (pc),
        .rf_we          (rf_we),
        .retire         (retire),
        .minstret       (minstret),
        .halted         (halted),
        .halt_code      (halt_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, PC0);
        chk({tag, "_inst"}, inst, 64'd0);
        chk({tag, "_minstret"}, minstret, 64'd0);
        chk({tag, "_halt_code"}, halt_code, 64'd0);
        chk({tag, "_ivalid"}, imem_req_valid, 64'd0);
        chk({tag, "_dvalid"}, dmem_req_valid, 64'd0);
        chk({tag, "_dwe"}, dmem_we, 64'd0);
        chk({tag, "_inst_valid"}, inst_valid, 64'd0);
        chk({tag, "_rf_we"}, rf_we, 64'd0);
        chk({tag, "_retire"}, retire, 64'd0);
        chk({tag, "_halted"}, halted, 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        dec_load       = 1'b0;
        dec_store      = 1'b0;
        dec_rd_wen     = 1'b0;
        dec_ebreak     = 1'b0;
        dec_illegal    = 1'b0;
        next_pc        = PC0 + 32'd4;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        imem_req_ready = 1'b1;
        rst_n          = 1'b1;

        // ALU instruction, zero-wait memories: FETCH, IWAIT, EXEC, WB
        @(negedge clk);
        chk("alu_fetch_valid", imem_req_valid, 64'd1);
        chk("alu_fetch_addr", imem_addr, PC0);
        @(negedge clk);
        chk("alu_iwait_valid", imem_req_valid, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0000_0013;
        @(negedge clk);
        chk("alu_exec_valid", inst_valid, 64'd1);
        chk("alu_inst", inst, 64'h13);
        imem_rsp_valid = 1'b0;
        dec_rd_wen     = 1'b1;
        @(negedge clk);
        chk("alu_wb_retire", retire, 64'd1);
        chk("alu_wb_rf_we", rf_we, 64'd1);
        dec_rd_wen = 1'b0;
        @(negedge clk);
        chk("alu_post_retire", retire, 64'd0);
        chk("alu_pc", pc, PC0 + 32'd4);
        chk("alu_minstret", minstret, 64'd1);
        chk("alu_next_fetch_addr", imem_addr, PC0 + 32'd4);

        // Load with dmem_req_ready held low for 3 cycles
        dmem_req_ready = 1'b0;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0000_2083;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dec_load       = 1'b1;
        dec_rd_wen     = 1'b1;
        next_pc        = PC0 + 32'd8;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("ld_req_held", dmem_req_valid, 64'd1);
            chk("ld_we", dmem_we, 64'd0);
            dec_load   = 1'b0;
            dec_rd_wen = 1'b0;
            if (i == 4) dmem_req_ready = 1'b1;
        end
        @(negedge clk);
        chk("ld_mwait_valid", dmem_req_valid, 64'd0);
        chk("ld_mwait_retire", retire, 64'd0);
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("ld_wb_retire", retire, 64'd1);
        chk("ld_wb_rf_we", rf_we, 64'd1);
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("ld_pc", pc, PC0 + 32'd8);
        chk("ld_minstret", minstret, 64'd2);

        // Store with rd_wen set: dmem_we high, no register write
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0020_2023;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dec_store      = 1'b1;
        dec_rd_wen     = 1'b1;
        next_pc        = PC0 + 32'd12;
        @(negedge clk);
        chk("st_req_valid", dmem_req_valid, 64'd1);
        chk("st_we", dmem_we, 64'd1);
        dec_store  = 1'b0;
        dec_rd_wen = 1'b0;
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("st_wb_rf_we", rf_we, 64'd0);
        chk("st_wb_retire", retire, 64'd1);
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("st_pc", pc, PC0 + 32'd12);
        chk("st_minstret", minstret, 64'd3);

        // Stray fetch response while FETCH is not yet accepted is ignored
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_rsp_fetch", imem_req_valid, 64'd1);
            chk("stray_rsp_exec", inst_valid, 64'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;

        // Misaligned next_pc in WB
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0000_0013;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        next_pc        = 32'h8000_0002;
        @(negedge clk);
        chk("mis_wb_retire", retire, 64'd0);
        @(negedge clk);
        chk("mis_halted", halted, 64'd1);
        chk("mis_code", halt_code, 64'd3);
        chk("mis_pc", pc, PC0 + 32'd12);
        chk("mis_minstret", minstret, 64'd3);
        chk("mis_no_fetch", imem_req_valid, 64'd0);

        // Reset asserted while waiting in IWAIT
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        next_pc = PC0 + 32'd4;
        @(negedge clk);
        chk("rst2_fetch_addr", imem_addr, PC0);
        @(negedge clk);
        chk("rst2_in_iwait", imem_req_valid, 64'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal and ebreak together: illegal wins, halt is absorbing
        @(negedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dec_illegal    = 1'b1;
        dec_ebreak     = 1'b1;
        @(negedge clk);
        chk("ill_halted", halted, 64'd1);
        chk("ill_code", halt_code, 64'd2);
        dec_illegal = 1'b0;
        dec_ebreak  = 1'b0;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (imem_req_valid) seen++;
        end
        chk("ill_no_fetch_100", seen, 64'd0);
        chk("ill_pc", pc, PC0);
        chk("ill_code_hold", halt_code, 64'd2);
        chk("ill_halted_hold", halted, 64'd1);

        // Ebreak alone
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'h0010_0073;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        dec_ebreak     = 1'b1;
        @(negedge clk);
        chk("ebk_code", halt_code, 64'd1);
        chk("ebk_halted", halted, 64'd1);
        dec_ebreak = 1'b0;

        // Fetch response never arrives
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
`ifdef NPC_CTRL_TIMEOUT_EN
        repeat (7) @(negedge clk);
        chk("to_not_yet", halted, 64'd0);
        @(negedge clk);
        chk("to_halted", halted, 64'd1);
        chk("to_code", halt_code, 64'd4);
`else
        repeat (20) @(negedge clk);
        chk("nto_still_waiting", halted, 64'd0);
        chk("nto_code", halt_code, 64'd0);
        chk("nto_no_fetch", imem_req_valid, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_ctrl_fsm.md
# npc_ctrl_fsm

Multi-cycle control sequencer for the NPC core. It owns the PC and the instruction register, and drives the instruction-fetch and data-memory handshakes. It samples the decode flags produced by the opcode/funct decoders and steps the datapath through fetch, execute, memory and writeback. It also raises a halt with a cause code on ebreak, illegal instruction, misaligned PC or (optionally) bus timeout.

## Interface
Parameters:
- PC_RESET, 32'h8000_0000, PC value loaded at reset
- TIMEOUT_CYCLES, 1024, maximum wait in IWAIT/MWAIT before a timeout halt (used only with NPC_CTRL_TIMEOUT_EN)

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  core clock
  - rst_n  in  1  asynchronous active-low reset
- Instruction memory:
  - imem_req_valid  out  1  fetch request
  - imem_req_ready  in  1  fetch request accepted
  - imem_addr  out  32  fetch address, equals pc
  - imem_rsp_valid  in  1  instruction data valid
  - imem_rdata  in  32  instruction word
- Decode and datapath:
  - inst  out  32  instruction register, feeds the decoders
  - inst_valid  out  1  high in EXEC only
  - dec_load / dec_store / dec_rd_wen / dec_ebreak / dec_illegal  in  1 each  decode flags, sampled in EXEC
  - next_pc  in  32  datapath-computed next PC, sampled in WB
- Data memory:
  - dmem_req_valid  out  1  data request
  - dmem_we  out  1  store (1) or load (0)
  - dmem_req_ready  in  1  data request accepted
  - dmem_rsp_valid  in  1  load data returned / store acknowledged
- Status:
  - pc  out  32  current PC
  - rf_we  out  1  register-file write enable
  - retire  out  1  one-cycle pulse per committed instruction
  - minstret  out  64  retired-instruction count
  - halted  out  1  sticky halt
  - halt_code  out  3  halt cause: 0 none, 1 ebreak, 2 illegal, 3 misaligned next_pc, 4 bus timeout

## Operation
- States: IDLE, FETCH, IWAIT, EXEC, MEM, MWAIT, WB, HALT.
- IDLE: entered only from reset; moves to FETCH on the next cycle.
- FETCH: imem_req_valid=1, imem_addr=pc; moves to IWAIT on imem_req_ready. imem_rsp_valid is ignored in FETCH.
- IWAIT: on imem_rsp_valid, inst<=imem_rdata and move to EXEC.
- EXEC: inst_valid=1. Flags are latched into ld/st/wen registers. Next state, in priority order:
  - dec_illegal -> HALT, code 2
  - dec_ebreak -> HALT, code 1
  - dec_load or dec_store -> MEM
  - otherwise -> WB
- MEM: dmem_req_valid=1, dmem_we=latched store flag; moves to MWAIT on dmem_req_ready.
- MWAIT: on dmem_rsp_valid, move to WB.
- WB:
  - rf_we = latched wen AND NOT store.
  - If next_pc[1:0]!=0 -> HALT, code 3; no retire, pc unchanged.
  - Otherwise pc<=next_pc, retire=1, minstret+1, move to FETCH.
- HALT: absorbing until reset. halted=1, all request outputs are 0, halt_code holds.
- All handshake outputs are decoded from state only, with no combinational path from inputs.

## Timing
- Reset values: state IDLE, pc=PC_RESET, inst=0, minstret=0, halt_code=0. Every 1-bit output is 0.
- A request is held (valid with address/we stable) until ready. Responses arrive no earlier than the cycle after acceptance.
- Minimum latency with ready=1 and a one-cycle response:
  - ALU op: 4 cycles per instruction (FETCH, IWAIT, EXEC, WB)
  - Load/store: 6 cycles per instruction
- minstret wraps from 2^64-1 to 0.
- Reset asserted mid-transaction aborts immediately. Outstanding responses arriving after reset in IDLE/FETCH are ignored.

## Configuration
- NPC_CTRL_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to IWAIT/MWAIT and counts each waiting cycle.
  - Reaching TIMEOUT_CYCLES without a response -> HALT, code 4.
- Undefined: no counter; waits are unbounded and code 4 never occurs.

## Structure
- Shared package npc_pkg: state encoding localparams, halt-code constants, PC_RESET default.
- One natural sub-module, npc_ctrl_watchdog: the timeout counter, instantiated only under the macro.

## Test plan
- Reset release, ALU inst at 0x80000000, both memories zero-wait, next_pc=0x80000004 -> imem_req_valid first high 1 cycle after reset; retire pulse in cycle 4; pc=0x80000004; minstret=1.
- Load, with dmem_req_ready delayed 3 cycles -> dmem_req_valid held 4 cycles; rf_we=1 in WB; retire follows dmem_rsp_valid by 1 cycle.
- Store with dec_rd_wen=1 -> dmem_we=1; rf_we stays 0 in WB.
- dec_illegal and dec_ebreak both high -> halted=1, halt_code=2; no further imem_req_valid for 100 cycles; pc unchanged.
- next_pc=0x80000002 in WB -> halt_code=3; retire=0; minstret unchanged.
- Macro on, TIMEOUT_CYCLES=8, imem_rsp_valid never asserted -> halt_code=4 exactly 8 cycles after entering IWAIT. Assert rst_n low in IWAIT on another run -> state IDLE, all outputs at reset values.
